// File: rtl/gcd_controller.sv
// gcd_controller: Moore FSM driving gcd_datapath through load/compare/subtract, with an iteration-limit abort.
// Optional: `define GCD_ITER_COUNT_EN adds the iter_count output port.
module gcd_controller #(
  parameter  int MAX_ITER = 255,
  localparam int CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic AgtB_dp,
  input  logic BgtA_dp,
  input  logic AeqB_dp,
  output logic load_dp,
  output logic AsubB_dp,
  output logic BsubA_dp,
  output logic AssignRes_dp,
  output logic busy,
  output logic done,
  output logic error
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [CNT_W-1:0] iter_count
`endif
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD   = 4'd1;
  localparam logic [3:0] S_WAIT   = 4'd2;
  localparam logic [3:0] S_CMP    = 4'd3;
  localparam logic [3:0] S_SUBA   = 4'd4;
  localparam logic [3:0] S_SUBB   = 4'd5;
  localparam logic [3:0] S_ASSIGN = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  // Saturating increment: the counter never wraps past the limit.
  assign cnt_inc = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT:   state_d = S_CMP;
      S_CMP: begin
        if (AeqB_dp)              state_d = S_ASSIGN;
        else if (cnt_q == MAX_CNT) state_d = S_ERR;
        else if (AgtB_dp)         state_d = S_SUBA;
        else if (BgtA_dp)         state_d = S_SUBB;
        else begin
          // No flag: re-sample the datapath, but charge it against the limit.
          cnt_d   = cnt_inc;
          state_d = S_WAIT;
        end
      end
      S_SUBA, S_SUBB: begin
        cnt_d   = cnt_inc;
        state_d = S_WAIT;
      end
      S_ASSIGN: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign load_dp      = (state_q == S_LOAD);
  assign AsubB_dp     = (state_q == S_SUBA);
  assign BsubA_dp     = (state_q == S_SUBB);
  assign AssignRes_dp = (state_q == S_ASSIGN);
  assign done         = (state_q == S_DONE) || (state_q == S_ERR);
  assign error        = (state_q == S_ERR);
  assign busy         = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_CMP) ||
                        (state_q == S_SUBA) || (state_q == S_SUBB) || (state_q == S_ASSIGN);

`ifdef GCD_ITER_COUNT_EN
  // Counter only changes between LOAD and DONE/ERR, so it is naturally frozen afterwards.
  assign iter_count = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller with MAX_ITER=4 and a small behavioural GCD datapath model.
module tb_gcd_controller;
  localparam int MAX_ITER = 4;
  localparam int CNT_W    = $clog2(MAX_ITER + 1);

  logic clk = 1'b0;
  logic rst, start;
  logic AgtB_dp, BgtA_dp, AeqB_dp;
  logic load_dp, AsubB_dp, BsubA_dp, AssignRes_dp, busy, done, error;
`ifdef GCD_ITER_COUNT_EN
  logic [CNT_W-1:0] iter_count;
`endif

  always #5 clk = ~clk;

  gcd_controller #(.MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .start(start),
    .AgtB_dp(AgtB_dp), .BgtA_dp(BgtA_dp), .AeqB_dp(AeqB_dp),
    .load_dp(load_dp), .AsubB_dp(AsubB_dp), .BsubA_dp(BsubA_dp),
    .AssignRes_dp(AssignRes_dp), .busy(busy), .done(done), .error(error)
`ifdef GCD_ITER_COUNT_EN
    , .iter_count(iter_count)
`endif
  );

  // Datapath model, with an override for forcing arbitrary flag patterns.
  logic [15:0] a_q, b_q, res_q, op_a, op_b;
  logic force_en, f_gt, f_lt, f_eq;
  always @(posedge clk) begin
    if (load_dp) begin
      a_q <= op_a;
      b_q <= op_b;
    end else if (AsubB_dp) a_q <= a_q - b_q;
    else if (BsubA_dp)     b_q <= b_q - a_q;
    if (AssignRes_dp) res_q <= a_q;
  end
  assign AgtB_dp = force_en ? f_gt : (a_q > b_q);
  assign BgtA_dp = force_en ? f_lt : (b_q > a_q);
  assign AeqB_dp = force_en ? f_eq : (a_q == b_q);

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {load_dp, AsubB_dp, BsubA_dp, AssignRes_dp, busy, done, error};
  endfunction

  // Start sampled in cycle 0; samples taken 1ns after each following rising edge (cycle c).
  int done_cyc, err_v, n_a, n_b, load_cyc, asg_cyc, multi, busy_at_done, iter_at_done;
  task automatic run(input logic [15:0] a, input logic [15:0] b, input bit hold);
    done_cyc = -1; err_v = -1; n_a = 0; n_b = 0; load_cyc = -1; asg_cyc = -1;
    multi = 0; busy_at_done = -1; iter_at_done = -1;
    op_a = a; op_b = b;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      if (load_dp && load_cyc < 0) load_cyc = c;
      if (AssignRes_dp && asg_cyc < 0) asg_cyc = c;
      if (AsubB_dp) n_a++;
      if (BsubA_dp) n_b++;
      if ($countones({load_dp, AsubB_dp, BsubA_dp, AssignRes_dp}) > 1) multi++;
      if (done) begin
        done_cyc     = c;
        err_v        = int'(error);
        busy_at_done = int'(busy);
`ifdef GCD_ITER_COUNT_EN
        iter_at_done = int'(iter_count);
`endif
      end
    end
    if (done_cyc < 0) begin
      total++; bad++;
      $display("FAIL run_timeout: got no done expected done within 60 cycles");
    end
  endtask

  typedef struct {
    logic [15:0] a, b;
    int exp_done, exp_err, exp_res, exp_na, exp_nb;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int   cnt;
    vecs[0] = '{16'd7,  16'd7,  5,  0, 7, 0, 0};
    vecs[1] = '{16'd12, 16'd8,  11, 0, 4, 1, 1};
    vecs[2] = '{16'd9,  16'd3,  11, 0, 3, 2, 0};
    vecs[3] = '{16'd5,  16'd15, 11, 0, 5, 0, 2};
    vecs[4] = '{16'd8,  16'd3,  17, 0, 1, 3, 1};  // equality wins at the limit
    vecs[5] = '{16'd9,  16'd2,  16, 1, 0, 4, 0};  // limit hit
    vecs[6] = '{16'd0,  16'd5,  16, 1, 0, 0, 4};  // zero operand never converges

    rst = 1'b1; start = 1'b0; force_en = 1'b0; f_gt = 0; f_lt = 0; f_eq = 0;
    op_a = '0; op_b = '0;
    #1;
    check("reset_outputs", 32'(outs()), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_outputs", 32'(outs()), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run(vecs[i].a, vecs[i].b, 1'b0);
      check($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].exp_done);
      check($sformatf("v%0d_error", i), err_v, vecs[i].exp_err);
      check($sformatf("v%0d_load_cycle", i), load_cyc, 1);
      check($sformatf("v%0d_asubb_count", i), n_a, vecs[i].exp_na);
      check($sformatf("v%0d_bsuba_count", i), n_b, vecs[i].exp_nb);
      check($sformatf("v%0d_busy_at_done", i), busy_at_done, 0);
      check($sformatf("v%0d_strobe_overlap", i), multi, 0);
      if (vecs[i].exp_err == 0) begin
        check($sformatf("v%0d_assign_cycle", i), asg_cyc, vecs[i].exp_done - 1);
        check($sformatf("v%0d_result", i), 32'(res_q), vecs[i].exp_res);
      end else begin
        check($sformatf("v%0d_no_assign", i), asg_cyc, -1);
      end
`ifdef GCD_ITER_COUNT_EN
      check($sformatf("v%0d_iter_count", i), iter_at_done, vecs[i].exp_na + vecs[i].exp_nb);
`endif
      @(posedge clk); #1;
      check($sformatf("v%0d_idle_after", i), 32'(outs()), 32'd0);
    end

    // Reset asserted during SUBA: outputs clear at once, no done follows.
    op_a = 16'd12; op_b = 16'd8;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_in_suba", 32'(AsubB_dp), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", 32'(outs()), 32'd0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done || busy) cnt++;
    end
    check("rst_mid_no_done", cnt, 0);

    // Start pulsed while busy and during the DONE cycle is ignored.
    op_a = 16'd7; op_b = 16'd7;
    @(negedge clk); start = 1'b1;
    cnt = 0; done_cyc = -1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      start = (c == 2) || (c == 5);
      if (load_dp && c >= 2) cnt++;
      if (done && done_cyc < 0) done_cyc = c;
    end
    start = 1'b0;
    check("ignore_start_done_cycle", done_cyc, 5);
    check("ignore_start_no_reload", cnt, 0);

    // Start held high: IDLE the cycle after done, LOAD the one after that.
    run(16'd7, 16'd7, 1'b1);
    check("hold_done_cycle", done_cyc, 5);
    @(posedge clk); #1;
    check("hold_idle_cycle", 32'(outs()), 32'd0);
    @(posedge clk); #1;
    check("hold_reload", 32'(load_dp), 32'd1);
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("hold_second_done", 32'(done), 32'd1);

    // Simultaneous AeqB and AgtB: equality has priority.
    force_en = 1'b1; f_eq = 1'b1; f_gt = 1'b1; f_lt = 1'b0;
    run(16'd1, 16'd1, 1'b0);
    check("simul_done_cycle", done_cyc, 5);
    check("simul_assign_cycle", asg_cyc, 4);
    check("simul_no_asubb", n_a, 0);
    check("simul_error", err_v, 0);

    // AgtB stuck high: exactly MAX_ITER subtractions then abort.
    f_eq = 1'b0; f_gt = 1'b1;
    run(16'd1, 16'd1, 1'b0);
    check("timeout_asubb_count", n_a, MAX_ITER);
    check("timeout_done_cycle", done_cyc, 4 + 3 * MAX_ITER);
    check("timeout_error", err_v, 1);
    check("timeout_busy_at_done", busy_at_done, 0);
`ifdef GCD_ITER_COUNT_EN
    check("timeout_iter_count", iter_at_done, MAX_ITER);
`endif
    @(posedge clk); #1;
    check("timeout_busy_after", 32'(busy), 32'd0);
    force_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
